// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: FSM states, opcode/funct
// constants, instruction classes and the select encodings seen by the datapath.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        C_NOP  = 4'd0,
        C_ADDU = 4'd1,
        C_SUBU = 4'd2,
        C_SLT  = 4'd3,
        C_JR   = 4'd4,
        C_ORI  = 4'd5,
        C_LUI  = 4'd6,
        C_LW   = 4'd7,
        C_SW   = 4'd8,
        C_BEQ  = 4'd9,
        C_J    = 4'd10,
        C_JAL  = 4'd11,
        C_ILL  = 4'd12
    } cls_t;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_MDR   = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;
    localparam logic [1:0] WD_SLT   = 2'b11;

    localparam logic [1:0] A3_RT    = 2'b00;
    localparam logic [1:0] A3_RD    = 2'b01;
    localparam logic [1:0] A3_RA    = 2'b10;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [2:0] ALU_ADDU = 3'b000;
    localparam logic [2:0] ALU_SUBU = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JT   = 2'b10;
    localparam logic [1:0] NPC_RS   = 2'b11;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational instruction classifier: op/funct to instruction class plus an
// unsupported-encoding flag.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output cls_t       cls,
    output logic       illegal
);

    always_comb begin
        cls = C_ILL;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls = C_ADDU;
                    FN_SUBU: cls = C_SUBU;
                    FN_SLT:  cls = C_SLT;
                    FN_JR:   cls = C_JR;
                    default: cls = C_ILL;
                endcase
            end
            OP_J:    cls = C_J;
            OP_JAL:  cls = C_JAL;
            OP_BEQ:  cls = C_BEQ;
            OP_ORI:  cls = C_ORI;
            OP_LUI:  cls = C_LUI;
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            default: cls = C_ILL;
        endcase
    end

    assign illegal = (cls == C_ILL);

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM with Moore output decode. Define CTRL_ILLEGAL_TRAP_EN
// to trap unsupported encodings into a sticky HALT; otherwise they retire as NOPs.
module mips_mc_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       pc_we,
    output logic       ir_we,
    output logic       mdr_we,
    output logic       rf_we,
    output logic [1:0] wd_sel,
    output logic [1:0] a3_sel,
    output logic       alub_sel,
    output logic [1:0] ext_op,
    output logic [2:0] alu_op,
    output logic [1:0] npc_sel,
    output logic       illegal
);

    // mem_req/ack: a request is held (mem_req=1, address and mem_we stable) until the
    // cycle mem_ack is high; that cycle completes the transfer and the FSM advances.
    state_t state, state_n;
    cls_t   cls_q, dec_cls;
    logic   dec_ill;

    mips_ctrl_decode u_decode (
        .op      (op),
        .funct   (funct),
        .cls     (dec_cls),
        .illegal (dec_ill)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            cls_q <= C_NOP;
        end else begin
            state <= state_n;
            if (state == S_DECODE)
                cls_q <= dec_cls;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (reset)
            illegal_q <= 1'b0;
        else if (state == S_DECODE && dec_ill)
            illegal_q <= 1'b1;
    end

    assign illegal = illegal_q & ~reset;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        iord     = 1'b0;
        pc_we    = 1'b0;
        ir_we    = 1'b0;
        mdr_we   = 1'b0;
        rf_we    = 1'b0;
        wd_sel   = WD_ALU;
        a3_sel   = A3_RT;
        alub_sel = 1'b0;
        ext_op   = EXT_ZERO;
        alu_op   = ALU_ADDU;
        npc_sel  = NPC_PC4;

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                // DECODE acts on the live decode; later states use the latched class.
                if (dec_ill) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_n = S_HALT;
`else
                    state_n = S_FETCH;
`endif
                end else begin
                    case (dec_cls)
                        C_J: begin
                            pc_we   = 1'b1;
                            npc_sel = NPC_JT;
                            state_n = S_FETCH;
                        end
                        C_JR: begin
                            pc_we   = 1'b1;
                            npc_sel = NPC_RS;
                            state_n = S_FETCH;
                        end
                        C_JAL:   state_n = S_WB;
                        default: state_n = S_EXEC;
                    endcase
                end
            end
            S_EXEC: begin
                state_n = S_WB;
                case (cls_q)
                    C_ADDU: alu_op = ALU_ADDU;
                    C_SUBU: alu_op = ALU_SUBU;
                    C_SLT:  alu_op = ALU_SLT;
                    C_ORI: begin
                        alub_sel = 1'b1;
                        ext_op   = EXT_ZERO;
                        alu_op   = ALU_OR;
                    end
                    C_LUI: begin
                        alub_sel = 1'b1;
                        ext_op   = EXT_LUI;
                        alu_op   = ALU_OR;
                    end
                    C_LW, C_SW: begin
                        alub_sel = 1'b1;
                        ext_op   = EXT_SIGN;
                        alu_op   = ALU_ADDU;
                        state_n  = S_MEM;
                    end
                    C_BEQ: begin
                        alu_op  = ALU_SUBU;
                        pc_we   = zero;
                        npc_sel = NPC_BR;
                        state_n = S_FETCH;
                    end
                    default: state_n = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (cls_q == C_SW);
                if (mem_ack) begin
                    if (cls_q == C_LW) begin
                        mdr_we  = 1'b1;
                        state_n = S_WB;
                    end else begin
                        state_n = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                state_n = S_FETCH;
                case (cls_q)
                    C_ADDU, C_SUBU: a3_sel = A3_RD;
                    C_SLT: begin
                        a3_sel = A3_RD;
                        wd_sel = WD_SLT;
                    end
                    C_LW: wd_sel = WD_MDR;
                    C_JAL: begin
                        a3_sel  = A3_RA;
                        wd_sel  = WD_PC4;
                        pc_we   = 1'b1;
                        npc_sel = NPC_JT;
                    end
                    default: ;
                endcase
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_FETCH;
        endcase

        // Reset abandons the instruction: only the fetch request is visible.
        if (reset) begin
            mem_req  = 1'b1;
            mem_we   = 1'b0;
            iord     = 1'b0;
            pc_we    = 1'b0;
            ir_we    = 1'b0;
            mdr_we   = 1'b0;
            rf_we    = 1'b0;
            wd_sel   = WD_ALU;
            a3_sel   = A3_RT;
            alub_sel = 1'b0;
            ext_op   = EXT_ZERO;
            alu_op   = ALU_ADDU;
            npc_sel  = NPC_PC4;
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: per-cycle rows of inputs with hand-computed
// output vectors and states, checked at the falling edge.
module tb_mips_mc_ctrl;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ack;
    logic       mem_req, mem_we, iord, pc_we, ir_we, mdr_we, rf_we;
    logic [1:0] wd_sel, a3_sel, ext_op, npc_sel;
    logic       alub_sel, illegal;
    logic [2:0] alu_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .mem_ack  (mem_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .iord     (iord),
        .pc_we    (pc_we),
        .ir_we    (ir_we),
        .mdr_we   (mdr_we),
        .rf_we    (rf_we),
        .wd_sel   (wd_sel),
        .a3_sel   (a3_sel),
        .alub_sel (alub_sel),
        .ext_op   (ext_op),
        .alu_op   (alu_op),
        .npc_sel  (npc_sel),
        .illegal  (illegal)
    );

    // {req,we,iord,pc_we,ir_we,mdr_we,rf_we,wd[2],a3[2],alub,ext[2],alu[3],npc[2],illegal}
    logic [19:0] outs;
    assign outs = {mem_req, mem_we, iord, pc_we, ir_we, mdr_we, rf_we, wd_sel, a3_sel,
                   alub_sel, ext_op, alu_op, npc_sel, illegal};

    localparam logic [19:0] O_REQ   = 20'h80000;
    localparam logic [19:0] O_WE    = 20'h40000;
    localparam logic [19:0] O_IORD  = 20'h20000;
    localparam logic [19:0] O_PCWE  = 20'h10000;
    localparam logic [19:0] O_IRWE  = 20'h08000;
    localparam logic [19:0] O_MDRWE = 20'h04000;
    localparam logic [19:0] O_RFWE  = 20'h02000;
    localparam logic [19:0] O_ALUB  = 20'h00100;
    localparam logic [19:0] O_ILL   = 20'h00001;
    localparam logic [19:0] F_ACK   = O_REQ | O_PCWE | O_IRWE;

    function automatic logic [19:0] f_wd(input logic [1:0] v);  return 20'(v) << 11; endfunction
    function automatic logic [19:0] f_a3(input logic [1:0] v);  return 20'(v) << 9;  endfunction
    function automatic logic [19:0] f_ext(input logic [1:0] v); return 20'(v) << 6;  endfunction
    function automatic logic [19:0] f_alu(input logic [2:0] v); return 20'(v) << 3;  endfunction
    function automatic logic [19:0] f_npc(input logic [1:0] v); return 20'(v) << 1;  endfunction

    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        ack;
        logic [19:0] eo;
        state_t      es;
    } row_t;

    row_t rq[$];

    function automatic row_t r(input logic rst, input logic [5:0] o, input logic [5:0] f,
                               input logic z, input logic ack, input logic [19:0] eo,
                               input state_t es);
        row_t x;
        x.rst = rst; x.op = o; x.fn = f; x.z = z; x.ack = ack; x.eo = eo; x.es = es;
        return x;
    endfunction

    task automatic test_reset();
        reset = 1'b1; op = 6'h00; funct = 6'h21; zero = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        rq.delete();
        rq.push_back(r(1, 6'h00, 6'h21, 0, 0, O_REQ, S_FETCH));
        rq.push_back(r(1, 6'h00, 6'h21, 0, 1, O_REQ, S_FETCH));
        foreach (rq[i]) begin
            reset = rq[i].rst; op = rq[i].op; funct = rq[i].fn; zero = rq[i].z; mem_ack = rq[i].ack;
            @(negedge clk);
            checks++;
            if (outs !== rq[i].eo || dut.state !== rq[i].es) begin
                errors++;
                $display("FAIL reset c%0d outs=%h state=%0d expected outs=%h state=%0d",
                         i, outs, dut.state, rq[i].eo, rq[i].es);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addu();
        rq.delete();
        rq.push_back(r(0, 6'h00, 6'h21, 0, 1, F_ACK, S_FETCH));
        rq.push_back(r(0, 6'h00, 6'h21, 0, 1, 20'h0, S_DECODE));
        rq.push_back(r(0, 6'h00, 6'h21, 0, 1, 20'h0, S_EXEC));
        rq.push_back(r(0, 6'h00, 6'h21, 0, 1, O_RFWE | f_a3(2'b01), S_WB));
        rq.push_back(r(0, 6'h00, 6'h21, 0, 0, O_REQ, S_FETCH));
        foreach (rq[i]) begin
            reset = rq[i].rst; op = rq[i].op; funct = rq[i].fn; zero = rq[i].z; mem_ack = rq[i].ack;
            @(negedge clk);
            checks++;
            if (outs !== rq[i].eo || dut.state !== rq[i].es) begin
                errors++;
                $display("FAIL addu c%0d outs=%h state=%0d expected outs=%h state=%0d",
                         i, outs, dut.state, rq[i].eo, rq[i].es);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_ops();
        rq.delete();
        rq.push_back(r(0, 6'h00, 6'h23, 0, 1, F_ACK, S_FETCH));
        rq.push_back(r(0, 6'h00, 6'h23, 0, 1, 20'h0, S_DECODE));
        rq.push_back(r(0, 6'h00, 6'h23, 0, 1, f_alu(3'b001), S_EXEC));
        rq.push_back(r(0, 6'h00, 6'h23, 0, 1, O_RFWE | f_a3(2'b01), S_WB));
        rq.push_back(r(0, 6'h00, 6'h2A, 0, 1, F_ACK, S_FETCH));
        rq.push_back(r(0, 6'h00, 6'h2A, 0, 1, 20'h0, S_DECODE));
        rq.push_back(r(0, 6'h00, 6'h2A, 0, 1, f_alu(3'b011), S_EXEC));
        rq.push_back(r(0, 6'h00, 6'h2A, 0, 1, O_RFWE | f_a3(2'b01) | f_wd(2'b11), S_WB));
        rq.push_back(r(0, 6'h0D, 6'h00, 0, 1, F_ACK, S_FETCH));
        rq.push_back(r(0, 6'h0D, 6'h00, 0, 1, 20'h0, S_DECODE));
        rq.push_back(r(0, 6'h0D, 6'h00, 0, 1, O_ALUB | f_alu(3'b010), S_EXEC));
        rq.push_back(r(0, 6'h0D, 6'h00, 0, 1, O_RFWE, S_WB));
        rq.push_back(r(0, 6'h0F, 6'h00, 0, 1, F_ACK, S_FETCH));
        rq.push_back(r(0, 6'h0F, 6'h00, 0, 1, 20'h0, S_DECODE));
        rq.push_back(r(0, 6'h0F, 6'h00, 0, 1, O_ALUB | f_ext(2'b10) | f_alu(3'b010), S_EXEC));
        rq.push_back(r(0, 6'h0F, 6'h00, 0, 1, O_RFWE, S_WB));
        foreach (rq[i]) begin
            reset = rq[i].rst; op = rq[i].op; funct = rq[i].fn; zero = rq[i].z; mem_ack = rq[i].ack;
            @(negedge clk);
            checks++;
            if (outs !== rq[i].eo || dut.state !== rq[i].es) begin
                errors++;
                $display("FAIL alu_ops c%0d outs=%h state=%0d expected outs=%h state=%0d",
                         i, outs, dut.state, rq[i].eo, rq[i].es);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem();
        rq.delete();
        // lw with three wait cycles in MEM, then sw with zero wait.
        rq.push_back(r(0, 6'h23, 6'h00, 0, 1, F_ACK, S_FETCH));
        rq.push_back(r(0, 6'h23, 6'h00, 0, 1, 20'h0, S_DECODE));
        rq.push_back(r(0, 6'h23, 6'h00, 0, 1, O_ALUB | f_ext(2'b01), S_EXEC));
        rq.push_back(r(0, 6'h23, 6'h00, 0, 0, O_REQ | O_IORD, S_MEM));
        rq.push_back(r(0, 6'h23, 6'h00, 0, 0, O_REQ | O_IORD, S_MEM));
        rq.push_back(r(0, 6'h23, 6'h00, 0, 0, O_REQ | O_IORD, S_MEM));
        rq.push_back(r(0, 6'h23, 6'h00, 0, 1, O_REQ | O_IORD | O_MDRWE, S_MEM));
        rq.push_back(r(0, 6'h23, 6'h00, 0, 1, O_RFWE | f_wd(2'b01), S_WB));
        rq.push_back(r(0, 6'h2B, 6'h00, 0, 1, F_ACK, S_FETCH));
        rq.push_back(r(0, 6'h2B, 6'h00, 0, 1, 20'h0, S_DECODE));
        rq.push_back(r(0, 6'h2B, 6'h00, 0, 1, O_ALUB | f_ext(2'b01), S_EXEC));
        rq.push_back(r(0, 6'h2B, 6'h00, 0, 1, O_REQ | O_IORD | O_WE, S_MEM));
        rq.push_back(r(0, 6'h2B, 6'h00, 0, 0, O_REQ, S_FETCH));
        foreach (rq[i]) begin
            reset = rq[i].rst; op = rq[i].op; funct = rq[i].fn; zero = rq[i].z; mem_ack = rq[i].ack;
            @(negedge clk);
            checks++;
            if (outs !== rq[i].eo || dut.state !== rq[i].es) begin
                errors++;
                $display("FAIL mem c%0d outs=%h state=%0d expected outs=%h state=%0d",
                         i, outs, dut.state, rq[i].eo, rq[i].es);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        rq.delete();
        rq.push_back(r(0, 6'h04, 6'h00, 1, 1, F_ACK, S_FETCH));
        rq.push_back(r(0, 6'h04, 6'h00, 1, 1, 20'h0, S_DECODE));
        rq.push_back(r(0, 6'h04, 6'h00, 1, 1, f_alu(3'b001) | O_PCWE | f_npc(2'b01), S_EXEC));
        rq.push_back(r(0, 6'h04, 6'h00, 0, 1, F_ACK, S_FETCH));
        rq.push_back(r(0, 6'h04, 6'h00, 0, 1, 20'h0, S_DECODE));
        rq.push_back(r(0, 6'h04, 6'h00, 0, 1, f_alu(3'b001) | f_npc(2'b01), S_EXEC));
        rq.push_back(r(0, 6'h02, 6'h00, 0, 1, F_ACK, S_FETCH));
        rq.push_back(r(0, 6'h02, 6'h00, 0, 1, O_PCWE | f_npc(2'b10), S_DECODE));
        rq.push_back(r(0, 6'h00, 6'h08, 0, 1, F_ACK, S_FETCH));
        rq.push_back(r(0, 6'h00, 6'h08, 0, 1, O_PCWE | f_npc(2'b11), S_DECODE));
        rq.push_back(r(0, 6'h03, 6'h00, 0, 1, F_ACK, S_FETCH));
        rq.push_back(r(0, 6'h03, 6'h00, 0, 1, 20'h0, S_DECODE));
        rq.push_back(r(0, 6'h03, 6'h00, 0, 1,
                       O_RFWE | f_a3(2'b10) | f_wd(2'b10) | O_PCWE | f_npc(2'b10), S_WB));
        rq.push_back(r(0, 6'h03, 6'h00, 0, 0, O_REQ, S_FETCH));
        foreach (rq[i]) begin
            reset = rq[i].rst; op = rq[i].op; funct = rq[i].fn; zero = rq[i].z; mem_ack = rq[i].ack;
            @(negedge clk);
            checks++;
            if (outs !== rq[i].eo || dut.state !== rq[i].es) begin
                errors++;
                $display("FAIL branch_jump c%0d outs=%h state=%0d expected outs=%h state=%0d",
                         i, outs, dut.state, rq[i].eo, rq[i].es);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_waits_and_reset();
        rq.delete();
        // Fetch wait states, then mem_ack toggling in DECODE/EXEC must be ignored.
        rq.push_back(r(0, 6'h00, 6'h21, 0, 0, O_REQ, S_FETCH));
        rq.push_back(r(0, 6'h00, 6'h21, 0, 1, F_ACK, S_FETCH));
        rq.push_back(r(0, 6'h00, 6'h21, 0, 0, 20'h0, S_DECODE));
        rq.push_back(r(0, 6'h00, 6'h21, 0, 0, 20'h0, S_EXEC));
        rq.push_back(r(0, 6'h00, 6'h21, 0, 0, O_RFWE | f_a3(2'b01), S_WB));
        // sw abandoned by reset while the store is pending in MEM.
        rq.push_back(r(0, 6'h2B, 6'h00, 0, 1, F_ACK, S_FETCH));
        rq.push_back(r(0, 6'h2B, 6'h00, 0, 1, 20'h0, S_DECODE));
        rq.push_back(r(0, 6'h2B, 6'h00, 0, 1, O_ALUB | f_ext(2'b01), S_EXEC));
        rq.push_back(r(0, 6'h2B, 6'h00, 0, 0, O_REQ | O_IORD | O_WE, S_MEM));
        rq.push_back(r(1, 6'h2B, 6'h00, 0, 1, O_REQ, S_MEM));
        rq.push_back(r(0, 6'h2B, 6'h00, 0, 0, O_REQ, S_FETCH));
        foreach (rq[i]) begin
            reset = rq[i].rst; op = rq[i].op; funct = rq[i].fn; zero = rq[i].z; mem_ack = rq[i].ack;
            @(negedge clk);
            checks++;
            if (outs !== rq[i].eo || dut.state !== rq[i].es) begin
                errors++;
                $display("FAIL waits_reset c%0d outs=%h state=%0d expected outs=%h state=%0d",
                         i, outs, dut.state, rq[i].eo, rq[i].es);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        rq.delete();
        rq.push_back(r(0, 6'h3F, 6'h00, 0, 1, F_ACK, S_FETCH));
        rq.push_back(r(0, 6'h3F, 6'h00, 0, 1, 20'h0, S_DECODE));
`ifdef CTRL_ILLEGAL_TRAP_EN
        rq.push_back(r(0, 6'h3F, 6'h00, 0, 1, O_ILL, S_HALT));
        rq.push_back(r(0, 6'h00, 6'h21, 0, 1, O_ILL, S_HALT));
        rq.push_back(r(0, 6'h00, 6'h21, 0, 0, O_ILL, S_HALT));
        rq.push_back(r(1, 6'h00, 6'h21, 0, 1, O_REQ, S_HALT));
        rq.push_back(r(0, 6'h00, 6'h21, 0, 0, O_REQ, S_FETCH));
`else
        rq.push_back(r(0, 6'h3F, 6'h00, 0, 0, O_REQ, S_FETCH));
        rq.push_back(r(0, 6'h00, 6'h00, 0, 1, F_ACK, S_FETCH));
        rq.push_back(r(0, 6'h00, 6'h00, 0, 1, 20'h0, S_DECODE));
        rq.push_back(r(0, 6'h00, 6'h00, 0, 0, O_REQ, S_FETCH));
`endif
        foreach (rq[i]) begin
            reset = rq[i].rst; op = rq[i].op; funct = rq[i].fn; zero = rq[i].z; mem_ack = rq[i].ack;
            @(negedge clk);
            checks++;
            if (outs !== rq[i].eo || dut.state !== rq[i].es) begin
                errors++;
                $display("FAIL illegal c%0d outs=%h state=%0d expected outs=%h state=%0d",
                         i, outs, dut.state, rq[i].eo, rq[i].es);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_alu_ops();
        test_mem();
        test_branch_jump();
        test_waits_and_reset();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle control unit for the MIPS datapath. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the select codes consumed by the datapath selectors: write-back data, destination register, ALU B source and next-PC. It also drives the PC, IR, MDR, register-file and data-memory write enables, and a req/ack handshake to a shared memory port.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU equality flag, valid in EXEC
- mem_ack  in  1  memory port completes current request this cycle
- mem_req  out  1  memory request (fetch or data)
- mem_we  out  1  data store, qualified by mem_req
- iord  out  1  0 = address from PC, 1 = address from ALU result
- pc_we, ir_we, mdr_we, rf_we  out  1 each  register write enables
- wd_sel  out  2  00 ALU, 01 MDR, 10 PC+4, 11 slt-less bit
- a3_sel  out  2  00 rt, 01 rd, 10 $31
- alub_sel  out  1  0 = rt data, 1 = extended immediate
- ext_op  out  2  00 zero-ext, 01 sign-ext, 10 lui (imm<<16)
- alu_op  out  3  000 addu, 001 subu, 010 or, 011 slt
- npc_sel  out  2  00 PC+4, 01 branch, 10 j/jal target, 11 rs (jr)
- illegal  out  1  unsupported op/funct decoded

## Operation
- Supported: addu, subu, slt, jr (op 0); ori, lui, lw, sw, beq, j, jal.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: mem_req=1, iord=0; hold until mem_ack. On the ack cycle: ir_we=1, pc_we=1, npc_sel=00, then DECODE.
- DECODE: class taken from op/funct. j: pc_we=1, npc_sel=10, next FETCH. jr: pc_we=1, npc_sel=11, next FETCH. jal: next WB. All others: next EXEC.
- EXEC: alu_op, alub_sel and ext_op per class. beq: alu_op=001; pc_we=zero, npc_sel=01; next FETCH. lw/sw: add with sign-ext; next MEM. All others: next WB.
- MEM: mem_req=1, iord=1, mem_we=(sw); hold until mem_ack. lw: mdr_we on the ack cycle, next WB. sw: next FETCH on ack.
- WB: rf_we=1 for exactly one cycle, then FETCH.
  - R-type: a3=01, wd=00, or wd=11 for slt.
  - ori/lui: a3=00, wd=00.
  - lw: a3=00, wd=01.
  - jal: a3=10, wd=10, plus pc_we=1, npc_sel=10.
- Outputs are Moore-decoded from the state and the class latched at DECODE. Exception: pc_we/ir_we/mdr_we in the wait states are gated by mem_ack.
- In every state, any enable not listed above is 0.

## Timing
- Reset (on the clock edge while reset=1): state=FETCH, class cleared, illegal=0.
- Output values during reset and in the first FETCH cycle: mem_req=1; all other outputs 0.
- Cycle counts with zero-wait memory (mem_ack high in the request cycle):
  - j, jr: 2 cycles.
  - beq: 3 cycles.
  - jal: 3 cycles.
  - R-type, ori, lui, sw: 4 cycles.
  - lw: 5 cycles.
- Each wait cycle with mem_ack=0 adds exactly one cycle. mem_req stays high and every enable stays 0 while waiting.
- mem_ack outside FETCH/MEM is ignored.
- Reset during any state, including mid-handshake, abandons the instruction: no enable fires on that edge, and the next state is FETCH.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: an unsupported op/funct in DECODE sets illegal=1 (sticky until reset), enters HALT, and all outputs stay 0 permanently.
- Undefined: unsupported encodings execute as a NOP (DECODE → FETCH, 2 cycles), illegal is tied 0, and HALT is unreachable.

## Structure
- Package mips_ctrl_pkg contains:
  - the state enum;
  - opcode/funct constants;
  - the instruction-class enum;
  - the encodings for wd_sel, a3_sel, ext_op, alu_op and npc_sel, shared with the datapath selectors.
- Sub-module mips_ctrl_decode: combinational op/funct → class and illegal flag. The FSM and output decode live in mips_mc_ctrl.

## Test plan
- Reset held 2 cycles, then released with mem_ack=1 and addu encoded (op 0, funct 0x21) → exact state sequence FETCH, DECODE, EXEC, WB; rf_we=1 in cycle 4 with a3_sel=01, wd_sel=00; back in FETCH at cycle 5.
- lw (op 0x23) with mem_ack low for 3 cycles in MEM → mem_req and iord stay high for 4 cycles; mdr_we pulses only on the ack cycle; WB has wd_sel=01, a3_sel=00; total 8 cycles.
- beq (op 0x04), once with zero=1 and once with zero=0 → pc_we=1 with npc_sel=01 in EXEC only when zero=1; 3 cycles either way.
- jal (op 0x03) → DECODE then WB with rf_we=1, a3_sel=10, wd_sel=10, pc_we=1, npc_sel=10; 3 cycles total.
- reset asserted in MEM during a pending sw → mem_we never coincides with mem_ack; next cycle is FETCH with mem_req=1.
- Unsupported op 0x3F → with CTRL_ILLEGAL_TRAP_EN: illegal=1, HALT, mem_req=0 thereafter. Without the macro: a 2-cycle NOP, then FETCH.
